// File: rtl/sfifo_stream_reader.sv
`default_nettype none
// ============================================================================
// sfifo_stream_reader: pops a BRAM FIFO, hides its read latency and presents
// the words as a valid/ready stream with flush, word count and underrun flag.
// Revision: 1.0
// ============================================================================
module sfifo_stream_reader #(
    parameter int DATA_WIDTH   = 36,
    parameter int READ_LATENCY = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clock0,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underrun,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_pop,
    output logic                  fifo_flush,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  underrun_seen
);

    localparam int BUF_DEPTH = READ_LATENCY + 1;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1) + 1;
    localparam int FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(BUF_DEPTH);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [FC_W-1:0]         flush_cnt, flush_cnt_nxt;
    logic                    enter_flush;

    logic [DATA_WIDTH-1:0]   buf_q   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_nxt [BUF_DEPTH];
    logic [OCC_W-1:0]        occ, occ_nxt;
    logic [OCC_W-1:0]        wr_slot;
    logic [READ_LATENCY-1:0] inflight, inflight_nxt;
    logic [OCC_W-1:0]        inflight_cnt;
    logic [OCC_W-1:0]        pending;
    logic                    deq;
    logic                    wr;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OCC_W'(inflight[i]);
        end
    end

    assign pending = occ + inflight_cnt;
    assign wr      = inflight[READ_LATENCY-1];
    assign m_valid = (occ != '0) && (state == ST_RUN);
    assign m_data  = buf_q[0];
    assign deq     = m_valid && m_ready;

    // Pop only when every issued read is guaranteed a buffer slot on return;
    // a same-cycle dequeue frees the slot, hence the m_ready path.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        enter_flush   = 1'b0;
        fifo_pop      = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    enter_flush   = 1'b1;
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = '0;
                end else if (reset_n && !fifo_empty &&
                             ((pending < DEPTH_V) || ((pending == DEPTH_V) && deq))) begin
                    fifo_pop = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FC_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        inflight_nxt[0] = fifo_pop;
        for (int i = 1; i < READ_LATENCY; i++) begin
            inflight_nxt[i] = inflight[i-1];
        end
    end

    // Shift-register buffer: head always at index 0, returning word lands
    // just behind the last valid entry after any dequeue.
    assign wr_slot = deq ? (occ - OCC_W'(1)) : occ;

    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_nxt[i] = buf_q[i];
        end
        occ_nxt = occ;
        if (deq) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                buf_nxt[i] = buf_q[i+1];
            end
            buf_nxt[BUF_DEPTH-1] = '0;
            occ_nxt = occ - OCC_W'(1);
        end
        if (wr) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (OCC_W'(i) == wr_slot) begin
                    buf_nxt[i] = fifo_dout;
                end
            end
            occ_nxt = occ_nxt + OCC_W'(1);
        end
    end

    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_RUN;
            flush_cnt     <= '0;
            fifo_flush    <= 1'b0;
            occ           <= '0;
            inflight      <= '0;
            word_count    <= '0;
            underrun_seen <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            fifo_flush <= enter_flush;
            if (enter_flush) begin
                occ           <= '0;
                inflight      <= '0;
                word_count    <= '0;
                underrun_seen <= 1'b0;
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    buf_q[i] <= '0;
                end
            end else begin
                occ      <= occ_nxt;
                inflight <= inflight_nxt;
                buf_q    <= buf_nxt;
                if (deq) begin
                    word_count <= word_count + 1'b1;
                end
                if (fifo_underrun) begin
                    underrun_seen <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfifo_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_sfifo_stream_reader: directed bench with a behavioural BRAM FIFO model.
// Revision: 1.0
// ============================================================================
module tb_sfifo_stream_reader;

    localparam int DW = 36;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fifo_empty;
    logic          fifo_underrun;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_count;
    logic          underrun_seen;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:127];
    int            rd_idx = 0;
    int            wr_idx = 0;

    int            pop_total  = 0;
    int            xfer_total = 0;
    int            max_out    = 0;
    logic          track_out  = 1'b1;
    logic          pop_when_empty = 1'b0;
    logic [DW-1:0] rx [0:63];
    int            rx_count = 0;

    always #5 clk = ~clk;

    sfifo_stream_reader #(
        .DATA_WIDTH  (DW),
        .READ_LATENCY(1),
        .FLUSH_CYCLES(2),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock0       (clk),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty),
        .fifo_underrun(fifo_underrun),
        .fifo_dout    (fifo_dout),
        .fifo_pop     (fifo_pop),
        .fifo_flush   (fifo_flush),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .word_count   (word_count),
        .underrun_seen(underrun_seen)
    );

    // FIFO model: one-cycle read latency, flush drops all stored words
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_idx <= wr_idx;
        end else if (fifo_pop && (rd_idx != wr_idx)) begin
            fifo_dout <= mem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_pop) pop_total <= pop_total + 1;
        if (fifo_pop && fifo_empty) pop_when_empty <= 1'b1;
        if (m_valid && m_ready) begin
            if (rx_count < 64) rx[rx_count] <= m_data;
            rx_count   <= rx_count + 1;
            xfer_total <= xfer_total + 1;
        end
        if (track_out && ((pop_total - xfer_total) > max_out)) begin
            max_out <= pop_total - xfer_total;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] exp_words [0:31];
        int            pops_before;
        int            n;

        reset_n       = 1'b0;
        m_ready       = 1'b1;
        flush         = 1'b0;
        fifo_underrun = 1'b0;
        for (int i = 1; i <= 8; i++) push(DW'(i));

        // reset state with a non-empty FIFO
        repeat (2) tick();
        #1;
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        chk("rst_fflush", 64'(fifo_flush), 64'd0);
        chk("rst_under", 64'(underrun_seen), 64'd0);

        tick(); reset_n = 1'b1; #1;
        chk("first_pop", 64'(fifo_pop), 64'd1);
        tick(); #1;
        chk("lat_valid0", 64'(m_valid), 64'd0);

        // streaming 0x1..0x8
        for (int j = 2; j <= 9; j++) begin
            tick(); #1;
            chk("stream_valid", 64'(m_valid), 64'd1);
            chk("stream_data", 64'(m_data), 64'(j - 1));
        end
        tick(); #1;
        chk("stream_end_valid", 64'(m_valid), 64'd0);
        chk("stream_count", 64'(word_count), 64'd8);
        chk("stream_under", 64'(underrun_seen), 64'd0);

        // backpressure: m_ready low for 5 cycles mid-stream
        for (int i = 9; i <= 14; i++) push(DW'(i));
        tick(); tick(); #1;
        chk("bp_data9", 64'(m_data), 64'h9);
        tick(); m_ready = 1'b0; #1;
        chk("bp_hold_data", 64'(m_data), 64'hA);
        chk("bp_hold_pop", 64'(fifo_pop), 64'd0);
        repeat (4) begin
            tick(); #1;
            chk("bp_hold_valid", 64'(m_valid), 64'd1);
            chk("bp_hold_data", 64'(m_data), 64'hA);
            chk("bp_hold_pop", 64'(fifo_pop), 64'd0);
        end
        tick(); m_ready = 1'b1; #1;
        chk("bp_resume", 64'(m_data), 64'hA);
        for (int j = 11; j <= 14; j++) begin
            tick(); #1;
            chk("bp_data", 64'(m_data), 64'(j));
        end
        tick(); #1;
        chk("bp_end_valid", 64'(m_valid), 64'd0);
        chk("bp_count", 64'(word_count), 64'd14);
        chk("bp_outstanding_le2", 64'(max_out <= 2), 64'd1);

        // empty boundary: single word
        pops_before = pop_total;
        push(DW'('h15)); #1;
        chk("eb_pop", 64'(fifo_pop), 64'd1);
        tick(); #1;
        chk("eb_pop_empty", 64'(fifo_pop), 64'd0);
        chk("eb_valid0", 64'(m_valid), 64'd0);
        tick(); #1;
        chk("eb_data", 64'(m_data), 64'h15);
        tick(); #1;
        chk("eb_valid_end", 64'(m_valid), 64'd0);
        chk("eb_count", 64'(word_count), 64'd15);
        chk("eb_one_pop", 64'(pop_total - pops_before), 64'd1);
        chk("eb_no_pop_empty", 64'(pop_when_empty), 64'd0);
        chk("eb_under", 64'(underrun_seen), 64'd0);

        // flush with two words buffered
        track_out = 1'b0;
        m_ready   = 1'b0;
        push(DW'('h21)); push(DW'('h22)); push(DW'('h23));
        tick(); tick(); tick(); #1;
        chk("fl_buf_valid", 64'(m_valid), 64'd1);
        chk("fl_buf_data", 64'(m_data), 64'h21);
        flush = 1'b1; #1;
        chk("fl_req_pop", 64'(fifo_pop), 64'd0);
        chk("fl_req_fflush", 64'(fifo_flush), 64'd0);
        tick(); flush = 1'b0; m_ready = 1'b1; #1;
        chk("fl_pulse", 64'(fifo_flush), 64'd1);
        chk("fl_valid_a", 64'(m_valid), 64'd0);
        chk("fl_count", 64'(word_count), 64'd0);
        chk("fl_no_pop", 64'(fifo_pop), 64'd0);
        tick(); #1;
        chk("fl_pulse_end", 64'(fifo_flush), 64'd0);
        chk("fl_valid_b", 64'(m_valid), 64'd0);
        tick(); #1;
        chk("fl_valid_c", 64'(m_valid), 64'd0);
        chk("fl_stale_gone", 64'(fifo_pop), 64'd0);
        push(DW'('h30)); #1;
        chk("fl_run_pop", 64'(fifo_pop), 64'd1);
        tick(); tick(); #1;
        chk("fl_new_data", 64'(m_data), 64'h30);
        tick(); #1;
        chk("fl_new_count", 64'(word_count), 64'd1);

        // counter wrap: 17 transfers since flush
        for (int i = 0; i < 16; i++) push(DW'('h40 + i));
        repeat (17) tick();
        #1;
        chk("wrap_zero", 64'(word_count), 64'd0);
        chk("wrap_last_data", 64'(m_data), 64'h4F);
        tick(); #1;
        chk("wrap_one", 64'(word_count), 64'd1);

        // sticky underrun cleared only by flush
        fifo_underrun = 1'b1;
        tick(); fifo_underrun = 1'b0; #1;
        chk("ur_set", 64'(underrun_seen), 64'd1);
        repeat (3) tick();
        #1;
        chk("ur_hold", 64'(underrun_seen), 64'd1);
        flush = 1'b1; #1;
        chk("ur_hold_req", 64'(underrun_seen), 64'd1);
        tick(); flush = 1'b0; #1;
        chk("ur_clear", 64'(underrun_seen), 64'd0);
        chk("ur_count_clear", 64'(word_count), 64'd0);
        repeat (3) tick();

        // scoreboard: every delivered word, in order
        n = 0;
        for (int i = 1; i <= 14; i++) begin exp_words[n] = DW'(i); n++; end
        exp_words[n] = DW'('h15); n++;
        exp_words[n] = DW'('h30); n++;
        for (int i = 0; i < 16; i++) begin exp_words[n] = DW'('h40 + i); n++; end
        chk("sb_count", 64'(rx_count), 64'(n));
        for (int i = 0; i < 32; i++) begin
            chk("sb_word", 64'(rx[i]), 64'(exp_words[i]));
        end

        // reset mid-operation: buffer lost, FIFO contents kept
        m_ready = 1'b0;
        push(DW'('h50)); push(DW'('h51)); push(DW'('h52));
        tick(); tick(); #1;
        chk("mr_valid", 64'(m_valid), 64'd1);
        chk("mr_data", 64'(m_data), 64'h50);
        reset_n = 1'b0; #1;
        chk("mr_async_valid", 64'(m_valid), 64'd0);
        chk("mr_async_data", 64'(m_data), 64'd0);
        chk("mr_async_pop", 64'(fifo_pop), 64'd0);
        tick(); reset_n = 1'b1; m_ready = 1'b1; #1;
        chk("mr_release_pop", 64'(fifo_pop), 64'd1);
        tick(); tick(); #1;
        chk("mr_kept_word", 64'(m_data), 64'h52);
        chk("mr_kept_valid", 64'(m_valid), 64'd1);
        tick(); #1;
        chk("mr_count", 64'(word_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
